// File: rtl/ar_pkg.sv
// Shared types and default sizes for the per-core address register bank.
package ar_pkg;
   typedef enum logic {AR_IDLE, AR_BURST} ar_state_t;
   localparam int AR_WIDTH = 16;
   localparam int AR_LEN_W = 4;
endpackage

// File: rtl/ar_channel.sv
// One per-core address register with burst sequencer.
// Optional circular BASE/LIMIT addressing when AR_LIMIT_EN is defined.
module ar_channel
   import ar_pkg::*;
#(
   parameter int WIDTH = AR_WIDTH,
   parameter int LEN_W = AR_LEN_W
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [WIDTH-1:0] bin,
   input  logic             wr,
`ifdef AR_LIMIT_EN
   input  logic             wrl,
`endif
   input  logic             inc,
   input  logic             dec,
   input  logic             start,
   input  logic [LEN_W-1:0] blen,
   input  logic             dmready,
   output logic [WIDTH-1:0] dmaddr,
   output logic             dmvalid,
   output logic             busy,
   output logic             done
);

   ar_state_t        state;
   logic [WIDTH-1:0] ar;
   logic [LEN_W-1:0] remaining;
   logic             busy_q;
   logic             done_q;

`ifdef AR_LIMIT_EN
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] limit;

   function automatic logic [WIDTH-1:0] next_up(input logic [WIDTH-1:0] a);
      return (a == limit) ? base : a + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] next_dn(input logic [WIDTH-1:0] a);
      return (a == base) ? limit : a - WIDTH'(1);
   endfunction
`else
   function automatic logic [WIDTH-1:0] next_up(input logic [WIDTH-1:0] a);
      return a + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] next_dn(input logic [WIDTH-1:0] a);
      return a - WIDTH'(1);
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= AR_IDLE;
         ar        <= '0;
         remaining <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef AR_LIMIT_EN
         base      <= '0;
         limit     <= '1;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            AR_IDLE: begin
`ifdef AR_LIMIT_EN
               if (wrl) limit <= bin;
`endif
               if (wr) begin
                  ar <= bin;
`ifdef AR_LIMIT_EN
                  base <= bin;
`endif
               end else if (start) begin
                  // A zero-length burst completes immediately without beats.
                  if (blen == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     remaining <= blen;
                     busy_q    <= 1'b1;
                     state     <= AR_BURST;
                  end
               end else if (inc) begin
                  ar <= next_up(ar);
               end else if (dec) begin
                  ar <= next_dn(ar);
               end
            end
            AR_BURST: begin
               if (dmready) begin
                  ar        <= next_up(ar);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state  <= AR_IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= AR_IDLE;
         endcase
      end
   end

   assign dmaddr  = ar;
   assign dmvalid = busy_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: rtl/ar_bank.sv
// Bank of CORES independent address registers feeding the data-memory ports.
// Define AR_LIMIT_EN to add WRL and circular BASE/LIMIT addressing.
module ar_bank
   import ar_pkg::*;
#(
   parameter int WIDTH = AR_WIDTH,
   parameter int CORES = 4,
   parameter int LEN_W = AR_LEN_W
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic [CORES*WIDTH-1:0] BIN,
   input  logic [CORES-1:0]       WR,
`ifdef AR_LIMIT_EN
   input  logic [CORES-1:0]       WRL,
`endif
   input  logic [CORES-1:0]       INC,
   input  logic [CORES-1:0]       DEC,
   input  logic [CORES-1:0]       START,
   input  logic [CORES*LEN_W-1:0] BLEN,
   input  logic [CORES-1:0]       DMREADY,
   output logic [CORES*WIDTH-1:0] DMADDR,
   output logic [CORES-1:0]       DMVALID,
   output logic [CORES-1:0]       BUSY,
   output logic [CORES-1:0]       DONE
);

   for (genvar c = 0; c < CORES; c++) begin : g_ch
      ar_channel #(
         .WIDTH (WIDTH),
         .LEN_W (LEN_W)
      ) u_ch (
         .clk     (clk),
         .RST     (RST),
         .bin     (BIN[c*WIDTH +: WIDTH]),
         .wr      (WR[c]),
`ifdef AR_LIMIT_EN
         .wrl     (WRL[c]),
`endif
         .inc     (INC[c]),
         .dec     (DEC[c]),
         .start   (START[c]),
         .blen    (BLEN[c*LEN_W +: LEN_W]),
         .dmready (DMREADY[c]),
         .dmaddr  (DMADDR[c*WIDTH +: WIDTH]),
         .dmvalid (DMVALID[c]),
         .busy    (BUSY[c]),
         .done    (DONE[c])
      );
   end

endmodule

// File: tb/tb_ar_bank.sv
// Scoreboard bench for ar_bank: expected beat addresses are queued at START
// and retired by a monitor as the bank presents accepted beats.
module tb_ar_bank;
   localparam int W = 16;
   localparam int N = 4;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           RST;
   logic [N*W-1:0] BIN;
   logic [N-1:0]   WR, INC, DEC, START, DMREADY;
`ifdef AR_LIMIT_EN
   logic [N-1:0]   WRL;
`endif
   logic [N*L-1:0] BLEN;
   logic [N*W-1:0] DMADDR;
   logic [N-1:0]   DMVALID, BUSY, DONE;

   int             n_chk = 0;
   int             n_bad = 0;
   logic [W-1:0]   exp_q [N][$];
   int             done_cnt [N];

   ar_bank #(.WIDTH(W), .CORES(N), .LEN_W(L)) dut (
      .clk     (clk),
      .RST     (RST),
      .BIN     (BIN),
      .WR      (WR),
`ifdef AR_LIMIT_EN
      .WRL     (WRL),
`endif
      .INC     (INC),
      .DEC     (DEC),
      .START   (START),
      .BLEN    (BLEN),
      .DMREADY (DMREADY),
      .DMADDR  (DMADDR),
      .DMVALID (DMVALID),
      .BUSY    (BUSY),
      .DONE    (DONE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] addr(input int c);
      return DMADDR[c*W +: W];
   endfunction

   task automatic push_burst(input int c, input logic [W-1:0] a0, input int len);
      for (int i = 0; i < len; i++) exp_q[c].push_back(a0 + W'(i));
   endtask

   // Monitor: sample mid-cycle, retire accepted beats, count DONE pulses.
   always @(negedge clk) begin
      if (!RST) begin
         for (int c = 0; c < N; c++) begin
            if (DMVALID[c]) begin
               chk("beat_pending", 32'(exp_q[c].size() != 0), 32'd1);
               if (exp_q[c].size() != 0) begin
                  chk("beat_addr", 32'(DMADDR[c*W +: W]), 32'(exp_q[c][0]));
                  if (DMREADY[c]) void'(exp_q[c].pop_front());
               end
            end
            if (DONE[c]) done_cnt[c]++;
         end
      end
   end

   initial begin
      logic [W-1:0] base [N];
      int           len [N];
      int           rem [N];
      logic         expd [N];
      logic         r;

      RST = 1'b1; BIN = '0; WR = '0; INC = '0; DEC = '0; START = '0;
      BLEN = '0; DMREADY = '0;
`ifdef AR_LIMIT_EN
      WRL = '0;
`endif
      for (int c = 0; c < N; c++) done_cnt[c] = 0;
      cyc(); cyc();
      chk("rst_addr", 32'(DMADDR), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_valid", 32'(DMVALID), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      RST = 1'b0;

      // Load and wrap
      BIN[0*W +: W] = 16'h1234; WR[0] = 1'b1; cyc(); WR = '0;
      chk("load_ch0", 32'(addr(0)), 32'h1234);
      for (int c = 1; c < N; c++) chk("load_other", 32'(addr(c)), 32'h0000);
      BIN[0*W +: W] = 16'hFFFF; WR[0] = 1'b1; cyc(); WR = '0;
      INC[0] = 1'b1; cyc(); INC = '0;
      chk("inc_wrap", 32'(addr(0)), 32'h0000);
      DEC[0] = 1'b1; cyc(); DEC = '0;
      chk("dec_wrap", 32'(addr(0)), 32'hFFFF);
      INC[0] = 1'b1; DEC[0] = 1'b1; cyc(); INC = '0; DEC = '0;
      chk("inc_dec", 32'(addr(0)), 32'h0000);
      BIN[0*W +: W] = 16'h0100; WR[0] = 1'b1; INC[0] = 1'b1; cyc(); WR = '0; INC = '0;
      chk("wr_over_inc", 32'(addr(0)), 32'h0100);

      // Burst with stalls and a mid-burst write
      push_burst(0, 16'h0100, 3);
      BLEN[0*L +: L] = 4'd3; START[0] = 1'b1; cyc(); START = '0;
      chk("burst_valid", 32'(DMVALID[0]), 32'd1);
      chk("burst_busy", 32'(BUSY[0]), 32'd1);
      DMREADY[0] = 1'b1; cyc();
      DMREADY[0] = 1'b0; BIN[0*W +: W] = 16'hAAAA; WR[0] = 1'b1; cyc(); WR = '0;
      DMREADY[0] = 1'b1; cyc();
      chk("burst_no_done", 32'(DONE[0]), 32'd0);
      cyc(); DMREADY[0] = 1'b0;
      chk("burst_done", 32'(DONE[0]), 32'd1);
      chk("burst_busy_off", 32'(BUSY[0]), 32'd0);
      chk("burst_final", 32'(addr(0)), 32'h0103);
      cyc();
      chk("burst_done_once", 32'(DONE[0]), 32'd0);
      chk("burst_done_cnt", 32'(done_cnt[0]), 32'd1);

      // Zero-length burst
      BLEN[0*L +: L] = 4'd0; START[0] = 1'b1; cyc(); START = '0;
      chk("zero_done", 32'(DONE[0]), 32'd1);
      chk("zero_valid", 32'(DMVALID[0]), 32'd0);
      chk("zero_addr", 32'(addr(0)), 32'h0103);
      cyc();
      chk("zero_done_off", 32'(DONE[0]), 32'd0);

      // Abort by reset mid-burst
      BIN[1*W +: W] = 16'h0200; WR[1] = 1'b1; cyc(); WR = '0;
      push_burst(1, 16'h0200, 5);
      BLEN[1*L +: L] = 4'd5; START[1] = 1'b1; cyc(); START = '0;
      DMREADY[1] = 1'b1; cyc(); cyc();
      RST = 1'b1; cyc(); RST = 1'b0; DMREADY = '0;
      exp_q[1].delete();
      chk("abort_addr", 32'(DMADDR), 32'd0);
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      cyc();
      chk("abort_no_done", 32'(DONE), 32'd0);
      chk("abort_done_cnt", 32'(done_cnt[1]), 32'd0);

      // Concurrent bursts on all channels
      len[0] = 3; len[1] = 5; len[2] = 2; len[3] = 7;
      for (int c = 0; c < N; c++) begin
         base[c] = W'((c + 1) << 12) + W'(c * 3);
         BIN[c*W +: W] = base[c];
         done_cnt[c] = 0;
      end
      WR = '1; cyc(); WR = '0;
      for (int c = 0; c < N; c++) begin
         push_burst(c, base[c], len[c]);
         BLEN[c*L +: L] = L'(len[c]);
         rem[c] = len[c];
      end
      START = '1; cyc(); START = '0;
      for (int t = 0; t < 30; t++) begin
         for (int c = 0; c < N; c++) begin
            case (c)
               0: r = 1'b1;
               1: r = (t % 2) == 1;
               2: r = 1'($urandom_range(0, 1));
               default: r = (t % 3) == 0;
            endcase
            DMREADY[c] = r;
            expd[c] = 1'b0;
            if (rem[c] > 0 && r) begin
               rem[c]--;
               expd[c] = (rem[c] == 0);
            end
         end
         cyc();
         for (int c = 0; c < N; c++) begin
            chk("multi_done", 32'(DONE[c]), 32'(expd[c]));
            chk("multi_busy", 32'(BUSY[c]), 32'(rem[c] > 0));
         end
      end
      DMREADY = '0;
      for (int c = 0; c < N; c++) begin
         chk("multi_final", 32'(addr(c)), 32'(base[c] + W'(len[c])));
         chk("multi_done_cnt", 32'(done_cnt[c]), 32'd1);
      end

`ifdef AR_LIMIT_EN
      // Circular addressing
      BIN[0*W +: W] = 16'h0010; WR[0] = 1'b1; cyc(); WR = '0;
      BIN[0*W +: W] = 16'h0012; WRL[0] = 1'b1; cyc(); WRL = '0;
      exp_q[0].push_back(16'h0010); exp_q[0].push_back(16'h0011);
      exp_q[0].push_back(16'h0012); exp_q[0].push_back(16'h0010);
      exp_q[0].push_back(16'h0011);
      BLEN[0*L +: L] = 4'd5; START[0] = 1'b1; cyc(); START = '0;
      DMREADY[0] = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      DMREADY = '0;
      chk("limit_done", 32'(DONE[0]), 32'd1);
      chk("limit_final", 32'(addr(0)), 32'h0012);
`endif

      cyc();
      for (int c = 0; c < N; c++) chk("queue_empty", 32'(exp_q[c].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
